// File: rtl/uart_rx_8n1.sv
// -----------------------------------------------------------------------------
// uart_rx_8n1
//   8N1 UART receiver for the PDU serial link.
//   The asynchronous serial line is brought into the clk domain through two
//   flops. The receiver detects the start bit and samples every bit at its
//   centre. Bytes are assembled LSB first. Each completed byte is handed to a
//   one-entry valid/ready output register.
//
// Parameters
//   CNT_FULL   bit period minus 1, in clk cycles (3 .. 1023)
//
// Ports
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  synchronous reset, active-high
//   en         in   1  receiver enable; low behaves exactly like rst
//   uart_rxd   in   1  asynchronous serial input, idles high
//   data       out  8  received byte, stable while valid=1
//   valid      out  1  data holds an unconsumed byte
//   ready      in   1  consumer takes data when valid & ready on a posedge
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   overrun    out  1  one-cycle pulse: new byte dropped, output register full
//   busy       out  1  high while a frame is in progress (START..WAIT_HIGH)
// -----------------------------------------------------------------------------
module uart_rx_8n1 #(
    parameter int unsigned CNT_FULL = 867
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       uart_rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Bit period and half bit period as 10-bit compare values.
    localparam logic [9:0] CNT_FULL_C = 10'(CNT_FULL);
    localparam logic [9:0] HALF_C     = CNT_FULL_C >> 1;

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_BITS      = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_e;

    state_e     state_q,     state_d;
    logic       sync1_q,     sync1_d;
    logic       sync2_q,     sync2_d;
    logic [9:0] cnt_q,       cnt_d;
    logic [2:0] bit_idx_q,   bit_idx_d;
    logic [7:0] shift_q,     shift_d;
    logic       deliver_q,   deliver_d;
    logic [7:0] data_q,      data_d;
    logic       valid_q,     valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q,   overrun_d;
    logic       busy_q,      busy_d;

    // Synchronised view of the serial line used by every decision below.
    logic rxd_s;
    assign rxd_s = sync2_q;

    // Next-state logic for the frame FSM, the output register and the flags.
    always_comb begin
        // Everything holds unless a branch below says otherwise.
        state_d     = state_q;
        sync1_d     = uart_rxd;
        sync2_d     = sync1_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        data_d      = data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer side: a handshake empties the output register.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // Delivery happens the cycle after a good stop bit. A byte taken by
        // the consumer in this same cycle frees the slot, so the new byte is
        // kept rather than reported as an overrun.
        if (deliver_q) begin
            if (!valid_q) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else if (ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_DISABLED: begin
                state_d = ST_IDLE;
                cnt_d   = 10'd0;
            end

            ST_IDLE: begin
                if (!rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = 10'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // Re-check the line half a bit after the falling edge; a high
            // level there means the edge was a glitch, not a start bit.
            ST_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d = 10'd0;
                    if (!rxd_s) begin
                        state_d   = ST_BITS;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            // Counting starts at the centre of the start bit, so each full
            // period lands in the centre of the next data bit.
            ST_BITS: begin
                if (cnt_q == CNT_FULL_C) begin
                    shift_d[bit_idx_q] = rxd_s;
                    cnt_d              = 10'd0;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_BITS;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            // The stop bit is sampled mid-bit, which leaves half a bit of
            // margin to catch a back-to-back start edge from IDLE.
            ST_STOP: begin
                if (cnt_q == CNT_FULL_C) begin
                    cnt_d = 10'd0;
                    if (rxd_s) begin
                        state_d   = ST_IDLE;
                        deliver_d = 1'b1;
                    end else begin
                        state_d     = ST_WAIT_HIGH;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            // Break or line noise: wait for the line to return to idle.
            ST_WAIT_HIGH: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end

            // Unused encodings recover to DISABLED with everything cleared.
            default: begin
                state_d     = ST_DISABLED;
                sync1_d     = 1'b1;
                sync2_d     = 1'b1;
                cnt_d       = 10'd0;
                bit_idx_d   = 3'd0;
                shift_d     = 8'd0;
                deliver_d   = 1'b0;
                data_d      = 8'd0;
                valid_d     = 1'b0;
                frame_err_d = 1'b0;
                overrun_d   = 1'b0;
            end
        endcase

        // busy is registered, so it is decoded from the next state.
        busy_d = (state_d == ST_START) || (state_d == ST_BITS) ||
                 (state_d == ST_STOP)  || (state_d == ST_WAIT_HIGH);
    end

    // State and output registers; rst or a dropped enable abort everything.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q     <= ST_DISABLED;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= 10'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            deliver_q   <= 1'b0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_8n1
//   Bench for uart_rx_8n1 with CNT_FULL=15 (16 clk cycles per bit).
//   Inputs change 1 ns after a posedge; outputs are observed on the negedge
//   or 1 ns after a posedge. Bytes that must reach the consumer are queued
//   when the frame is sent and popped when a valid & ready handshake is seen.
// -----------------------------------------------------------------------------
module tb_uart_rx_8n1;

    localparam int unsigned CNT_FULL = 15;
    localparam int          BIT_CYC  = 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic       uart_rxd;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int fe_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_8n1 #(.CNT_FULL(CNT_FULL)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .uart_rxd  (uart_rxd),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer monitor: counts flag pulses and scores every handshake.
    always @(negedge clk) begin
        if (!rst && en) begin
            if (frame_err || overrun) begin
                checks++;
                if (frame_err && overrun) begin
                    errors++;
                    $display("FAIL flags_exclusive: frame_err=%b overrun=%b, required not both 1",
                             frame_err, overrun);
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun) ovr_cnt++;
            if (valid && ready) begin
                logic [7:0] exp;
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got data=%02h, required no byte", data);
                end else begin
                    exp = exp_q.pop_front();
                    if (data !== exp) begin
                        errors++;
                        $display("FAIL rx_data: got %02h, required %02h", data, exp);
                    end
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        hs_cnt  = 0;
        fe_cnt  = 0;
        ovr_cnt = 0;
    endtask

    // Sends one frame. bad_stop holds the stop bit low for 3 bit times.
    // abort_bit >= 0 pulses rst (or drops en) for one cycle mid-way
    // through that data bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_stop,
                              input int abort_bit, input bit abort_en);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < 9; i++) begin
            uart_rxd = (i == 0) ? 1'b0 : v[3'(i - 1)];
            for (int c = 0; c < BIT_CYC; c++) begin
                if (abort_bit >= 0 && i == abort_bit + 1 && c == 8) begin
                    if (abort_en) en = 1'b0;
                    else rst = 1'b1;
                    tick(1);
                    en  = 1'b1;
                    rst = 1'b0;
                end else begin
                    tick(1);
                end
            end
        end
        if (bad_stop) begin
            uart_rxd = 1'b0;
            tick(3 * BIT_CYC);
        end
        uart_rxd = 1'b1;
        tick(BIT_CYC);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; uart_rxd = 1'b1; ready = 1'b1;
        tick(3);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, required 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst = 1'b0;
        tick(3);
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b valid=%b, required 0 0", busy, valid); end
    endtask

    task automatic test_single_frame();
        clear_counts();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, -1, 1'b0);
        tick(4);
        checks++; if (hs_cnt !== 1) begin errors++; $display("FAIL a5_count: got %0d bytes, required 1", hs_cnt); end
        checks++; if (fe_cnt !== 0 || ovr_cnt !== 0) begin errors++; $display("FAIL a5_flags: frame_err=%0d overrun=%0d, required 0 0", fe_cnt, ovr_cnt); end
        checks++; if (data !== 8'hA5 || valid !== 1'b0) begin errors++; $display("FAIL a5_after: data=%02h valid=%b, required a5 0", data, valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pats [4];
        pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h5A; pats[3] = 8'h01;
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pats[k]);
            send_frame(pats[k], 1'b0, -1, 1'b0);
        end
        tick(4);
        checks++; if (hs_cnt !== 4) begin errors++; $display("FAIL b2b_count: got %0d bytes, required 4", hs_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: %0d bytes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_glitch();
        clear_counts();
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b, required 1", busy); end
        tick(12);
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy=%b valid=%b, required 0 0", busy, valid); end
        checks++; if (fe_cnt !== 0 || hs_cnt !== 0) begin errors++; $display("FAIL glitch_flags: frame_err=%0d bytes=%0d, required 0 0", fe_cnt, hs_cnt); end
    endtask

    task automatic test_frame_err();
        clear_counts();
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles, required 1", fe_cnt); end
        checks++; if (hs_cnt !== 0 || valid !== 1'b0) begin errors++; $display("FAIL ferr_no_byte: bytes=%0d valid=%b, required 0 0", hs_cnt, valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_recover_busy: got %b, required 0", busy); end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, -1, 1'b0);
        tick(4);
        checks++; if (hs_cnt !== 1 || data !== 8'h81) begin errors++; $display("FAIL ferr_next: bytes=%0d data=%02h, required 1 81", hs_cnt, data); end
    endtask

    task automatic test_overrun();
        clear_counts();
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, -1, 1'b0);
        send_frame(8'h22, 1'b0, -1, 1'b0);
        tick(4);
        checks++; if (valid !== 1'b1 || data !== 8'h11) begin errors++; $display("FAIL ovr_hold: valid=%b data=%02h, required 1 11", valid, data); end
        checks++; if (ovr_cnt !== 1 || fe_cnt !== 0) begin errors++; $display("FAIL ovr_pulse: overrun=%0d frame_err=%0d, required 1 0", ovr_cnt, fe_cnt); end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        checks++; if (valid !== 1'b0 || hs_cnt !== 1) begin errors++; $display("FAIL ovr_drain: valid=%b bytes=%0d, required 0 1", valid, hs_cnt); end
        ready = 1'b1;
    endtask

    task automatic test_ready_at_delivery();
        clear_counts();
        ready = 1'b0;
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b0, -1, 1'b0);
        tick(2);
        checks++; if (valid !== 1'b1 || data !== 8'h33) begin errors++; $display("FAIL rad_first: valid=%b data=%02h, required 1 33", valid, data); end
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b0, -1, 1'b0);
            begin
                int n;
                n = 0;
                while (!busy && n < 400) begin tick(1); n++; end
                while (busy && n < 400) begin tick(1); n++; end
                if (n >= 400) begin
                    checks++; errors++;
                    $display("FAIL rad_timeout: busy did not fall within 400 cycles");
                end else begin
                    // busy has just fallen at the stop sample; the next edge delivers.
                    ready = 1'b1;
                    tick(1);
                    ready = 1'b0;
                    checks++; if (data !== 8'h55 || valid !== 1'b1) begin errors++; $display("FAIL rad_deliver: data=%02h valid=%b, required 55 1", data, valid); end
                    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL rad_overrun: got %0d, required 0", ovr_cnt); end
                end
            end
        join
        tick(2);
        ready = 1'b1;
        tick(1);
        checks++; if (valid !== 1'b0 || hs_cnt !== 2) begin errors++; $display("FAIL rad_drain: valid=%b bytes=%0d, required 0 2", valid, hs_cnt); end
    endtask

    task automatic test_abort();
        clear_counts();
        ready = 1'b1;
        send_frame(8'hFF, 1'b0, 3, 1'b0);
        tick(4);
        checks++; if (hs_cnt !== 0 || fe_cnt !== 0 || ovr_cnt !== 0) begin errors++; $display("FAIL abort_rst_quiet: bytes=%0d ferr=%0d ovr=%0d, required 0 0 0", hs_cnt, fe_cnt, ovr_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_rst_busy: got %b, required 0", busy); end
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, -1, 1'b0);
        tick(4);
        checks++; if (hs_cnt !== 1 || data !== 8'h0F) begin errors++; $display("FAIL abort_next: bytes=%0d data=%02h, required 1 0f", hs_cnt, data); end

        // Dropping en must also discard a byte still waiting for the consumer.
        clear_counts();
        ready = 1'b0;
        send_frame(8'h42, 1'b0, -1, 1'b0);
        tick(2);
        checks++; if (valid !== 1'b1 || data !== 8'h42) begin errors++; $display("FAIL abort_en_pending: valid=%b data=%02h, required 1 42", valid, data); end
        send_frame(8'hFF, 1'b0, 3, 1'b1);
        tick(4);
        checks++; if (valid !== 1'b0 || data !== 8'h00) begin errors++; $display("FAIL abort_en_clear: valid=%b data=%02h, required 0 00", valid, data); end
        checks++; if (fe_cnt !== 0 || ovr_cnt !== 0) begin errors++; $display("FAIL abort_en_flags: ferr=%0d ovr=%0d, required 0 0", fe_cnt, ovr_cnt); end
        ready = 1'b1;
        tick(4);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; uart_rxd = 1'b1; ready = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_ready_at_delivery();
        test_abort();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d bytes never delivered, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
